// File: rtl/mig_app_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : mig_app_pkg
// Brief  : Shared command codes and command-queue entry type for the MIG
//          application-port responder.
// Rev    : 1.0  initial release
// ============================================================================
package mig_app_pkg;

    localparam logic [2:0] MIG_CMD_WRITE    = 3'b000;
    localparam logic [2:0] MIG_CMD_READ     = 3'b001;
    localparam int         MIG_ADDRESS_SIZE = 28;

    typedef struct packed {
        logic [2:0]                  cmd;
        logic [MIG_ADDRESS_SIZE-1:0] addr;
    } mig_cmd_entry_t;

endpackage
`default_nettype wire

// File: rtl/mig_app_responder_if.sv
`default_nettype none
// ============================================================================
// Module : mig_app_responder_if
// Brief  : MIG user-interface (app_*) signal bundle; master drives commands.
// Rev    : 1.0  initial release
// ============================================================================
interface mig_app_responder_if #(
    parameter int CHUNK_PART   = 128,
    parameter int ADDRESS_SIZE = 28
);
    logic [ADDRESS_SIZE-1:0]  app_addr;
    logic [2:0]               app_cmd;
    logic                     app_en;
    logic                     app_rdy;
    logic [CHUNK_PART-1:0]    app_wdf_data;
    logic [CHUNK_PART/8-1:0]  app_wdf_mask;
    logic                     app_wdf_wren;
    logic                     app_wdf_end;
    logic                     app_wdf_rdy;
    logic [CHUNK_PART-1:0]    app_rd_data;
    logic                     app_rd_data_valid;
    logic                     app_rd_data_end;
    logic                     init_calib_complete;
    logic [3:0]               error;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, init_calib_complete, error
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
               app_rd_data_end, init_calib_complete, error
    );
endinterface
`default_nettype wire

// File: rtl/mig_app_responder_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : mig_app_responder_sync_fifo
// Brief  : Single-clock FIFO, 2**DEPTH_LOG2 entries, push+pop legal when full.
// Rev    : 1.0  initial release
// ============================================================================
module mig_app_responder_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             i_push,
    input  wire [WIDTH-1:0] i_din,
    input  wire             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic            o_full,
    output logic            o_empty
);
    localparam int c_depth = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    r_mem [c_depth];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                w_do_push;
    logic                w_do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                       (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_din;
    end
endmodule
`default_nettype wire

// File: rtl/mig_app_responder.sv
`default_nettype none
// ============================================================================
// Module : mig_app_responder
// Brief  : Behavioural MIG app-port responder: calibration delay, command and
//          write-data queues, in-order execution against a byte-masked store.
// Rev    : 1.0  initial release
// ============================================================================
module mig_app_responder
    import mig_app_pkg::*;
#(
    parameter int CHUNK_PART   = 128,
    parameter int ADDRESS_SIZE = 28,
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 4,
    parameter int CALIB_CYCLES = 16,
    parameter int STALL_PERIOD = 0
) (
    input  wire                clk,
    input  wire                reset,
    mig_app_responder_if.slave app
);
    localparam int c_beat_bytes = CHUNK_PART / 8;
    localparam int c_dat_w      = CHUNK_PART + c_beat_bytes;
    localparam int c_cal_w      = $clog2(CALIB_CYCLES + 1);

    mig_cmd_entry_t          w_cmd_in;
    mig_cmd_entry_t          w_cmd_head;
    logic [ADDRESS_SIZE-1:0] w_addr;
    logic                    w_cmd_known;
    logic                    w_cmd_push;
    logic                    w_cmd_full;
    logic                    w_cmd_empty;
    logic [c_dat_w-1:0]      w_dat_head;
    logic                    w_dat_push;
    logic                    w_dat_full;
    logic                    w_dat_empty;
    logic                    w_exec_wr;
    logic                    w_exec_rd;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_stall;
    logic                    w_unused_addr;

    logic [c_cal_w-1:0]      r_cal_cnt;
    logic                    r_calib;
    logic [2:0]              r_error;
    logic [CHUNK_PART-1:0]   r_store [2 ** DEPTH_LOG2];
    logic [CHUNK_PART-1:0]   r_pipe_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pipe_vld;

    // ---------------------------------------------------------------- calib
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cal_cnt <= '0;
            r_calib   <= 1'b0;
        end else if (!r_calib) begin
            r_cal_cnt <= r_cal_cnt + 1'b1;
            if (r_cal_cnt == c_cal_w'(CALIB_CYCLES - 1)) r_calib <= 1'b1;
        end
    end

    generate
        if (STALL_PERIOD > 0) begin : g_stall
            localparam int c_stall_w = $clog2(STALL_PERIOD + 1);
            logic [c_stall_w-1:0] r_stall_cnt;

            always_ff @(posedge clk) begin
                if (reset || w_stall) r_stall_cnt <= '0;
                else                  r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            assign w_stall = (r_stall_cnt == c_stall_w'(STALL_PERIOD - 1));
        end else begin : g_no_stall
            assign w_stall = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------ acceptance
    assign app.app_rdy     = r_calib && !w_cmd_full && !w_stall;
    assign app.app_wdf_rdy = r_calib && !w_dat_full;

    assign w_addr        = app.app_addr;
    assign w_cmd_known   = (app.app_cmd == MIG_CMD_WRITE) || (app.app_cmd == MIG_CMD_READ);
    // Unknown opcodes are flagged and dropped here so they never reach the head.
    assign w_cmd_push    = app.app_en && app.app_rdy && w_cmd_known;
    assign w_cmd_in.cmd  = app.app_cmd;
    assign w_cmd_in.addr = MIG_ADDRESS_SIZE'(w_addr);
    assign w_dat_push    = app.app_wdf_wren && app.app_wdf_rdy;

    mig_app_responder_sync_fifo #(
        .WIDTH      ($bits(mig_cmd_entry_t)),
        .DEPTH_LOG2 (2)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_cmd_push),
        .i_din   (w_cmd_in),
        .i_pop   (w_exec_wr || w_exec_rd),
        .o_dout  (w_cmd_head),
        .o_full  (w_cmd_full),
        .o_empty (w_cmd_empty)
    );

    mig_app_responder_sync_fifo #(
        .WIDTH      (c_dat_w),
        .DEPTH_LOG2 (2)
    ) u_dat_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_dat_push),
        .i_din   ({app.app_wdf_mask, app.app_wdf_data}),
        .i_pop   (w_exec_wr),
        .o_dout  (w_dat_head),
        .o_full  (w_dat_full),
        .o_empty (w_dat_empty)
    );

    // ------------------------------------------------------------- execution
    // A head write without data stalls everything behind it, keeping RAW order.
    assign w_exec_wr     = !w_cmd_empty && (w_cmd_head.cmd == MIG_CMD_WRITE) && !w_dat_empty;
    assign w_exec_rd     = !w_cmd_empty && (w_cmd_head.cmd == MIG_CMD_READ);
    assign w_idx         = w_cmd_head.addr[3 +: DEPTH_LOG2];
    assign w_unused_addr = ^w_cmd_head.addr;

    always_ff @(posedge clk) begin
        if (w_exec_wr && !reset) begin
            for (int b = 0; b < c_beat_bytes; b++) begin
                if (!w_dat_head[CHUNK_PART + b]) r_store[w_idx][8*b +: 8] <= w_dat_head[8*b +: 8];
            end
        end
    end

    // Data stages only advance behind a valid beat, so the last one holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld <= '0;
            for (int s = 0; s < READ_LATENCY; s++) r_pipe_data[s] <= '0;
        end else begin
            r_pipe_vld[0] <= w_exec_rd;
            if (w_exec_rd) r_pipe_data[0] <= r_store[w_idx];
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
                if (r_pipe_vld[s-1]) r_pipe_data[s] <= r_pipe_data[s-1];
            end
        end
    end

    assign app.app_rd_data         = r_pipe_data[READ_LATENCY-1];
    assign app.app_rd_data_valid   = r_pipe_vld[READ_LATENCY-1];
    assign app.app_rd_data_end     = r_pipe_vld[READ_LATENCY-1];
    assign app.init_calib_complete = r_calib;

    // ---------------------------------------------------------------- errors
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= '0;
        end else begin
            if (app.app_en && app.app_rdy && !w_cmd_known)         r_error[0] <= 1'b1;
            if (app.app_wdf_wren && !app.app_wdf_end)              r_error[1] <= 1'b1;
            if ((app.app_en || app.app_wdf_wren) && !r_calib)      r_error[2] <= 1'b1;
        end
    end

    assign app.error = {1'b0, r_error};
endmodule
`default_nettype wire

// File: tb/tb_mig_app_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mig_app_responder
// Brief  : Directed self-checking bench; one unstalled and one stalled responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mig_app_responder;
    import mig_app_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mig_app_responder_if #(.CHUNK_PART(128), .ADDRESS_SIZE(28)) m ();
    mig_app_responder_if #(.CHUNK_PART(128), .ADDRESS_SIZE(28)) s ();

    mig_app_responder #(
        .CHUNK_PART(128), .ADDRESS_SIZE(28), .DEPTH_LOG2(10),
        .READ_LATENCY(4), .CALIB_CYCLES(16), .STALL_PERIOD(0)
    ) dut (.clk(clk), .reset(reset), .app(m));

    mig_app_responder #(
        .CHUNK_PART(128), .ADDRESS_SIZE(28), .DEPTH_LOG2(10),
        .READ_LATENCY(4), .CALIB_CYCLES(16), .STALL_PERIOD(3)
    ) dut_s (.clk(clk), .reset(reset), .app(s));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_vld_cnt = 0;
    int cnt0;
    logic [127:0] q_s [$];

    localparam logic [127:0] D1 = 128'h0123456789ABCDEF01234567DEADBEEF;
    localparam logic [127:0] D2 = 128'hFFEEDDCCBBAA99887766554433221100;
    localparam logic [127:0] F11 = 128'h11111111111111111111111111111111;
    localparam logic [127:0] DM = 128'h11111111111111111111111133221100;

    logic [27:0]  s_addr [4];
    logic [127:0] s_data [4];

    always @(negedge clk) begin
        if (m.app_rd_data_valid === 1'b1) m_vld_cnt++;
        if (s.app_rd_data_valid === 1'b1) q_s.push_back(s.app_rd_data);
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_m();
        logic a, w;
        a = m.app_en && m.app_rdy;
        w = m.app_wdf_wren && m.app_wdf_rdy;
        tick();
        if (a) m.app_en = 1'b0;
        if (w) m.app_wdf_wren = 1'b0;
    endtask

    task automatic wait_m(input string tag);
        for (int k = 0; k < 20 && (m.app_en || m.app_wdf_wren); k++) step_m();
        check(tag, {m.app_en, m.app_wdf_wren}, 0);
    endtask

    task automatic send_cmd_m(input logic [2:0] cmd, input logic [27:0] addr);
        m.app_cmd = cmd; m.app_addr = addr; m.app_en = 1'b1;
        wait_m("cmd_accept");
    endtask

    task automatic send_data_m(input logic [127:0] data, input logic [15:0] mask);
        m.app_wdf_data = data; m.app_wdf_mask = mask; m.app_wdf_end = 1'b1; m.app_wdf_wren = 1'b1;
        wait_m("data_accept");
    endtask

    task automatic read_check_m(input logic [27:0] addr, input logic [127:0] exp, input string tag);
        send_cmd_m(MIG_CMD_READ, addr);
        for (int k = 0; k < 12 && m.app_rd_data_valid !== 1'b1; k++) tick();
        check({tag, "_valid"}, m.app_rd_data_valid, 1'b1);
        check(tag, m.app_rd_data, exp);
    endtask

    // The stalled responder drops app_rdy whenever (edges since reset) mod 3 == 2.
    task automatic step_s();
        logic a, w;
        check("stall_rdy", s.app_rdy, (cyc % 3) != 2);
        a = s.app_en && s.app_rdy;
        w = s.app_wdf_wren && s.app_wdf_rdy;
        tick();
        if (a) s.app_en = 1'b0;
        if (w) s.app_wdf_wren = 1'b0;
    endtask

    task automatic wait_s(input string tag);
        for (int k = 0; k < 20 && (s.app_en || s.app_wdf_wren); k++) step_s();
        check(tag, {s.app_en, s.app_wdf_wren}, 0);
    endtask

    initial begin
        m.app_addr = '0; m.app_cmd = '0; m.app_en = 0; m.app_wdf_data = '0;
        m.app_wdf_mask = '0; m.app_wdf_wren = 0; m.app_wdf_end = 1;
        s.app_addr = '0; s.app_cmd = '0; s.app_en = 0; s.app_wdf_data = '0;
        s.app_wdf_mask = '0; s.app_wdf_wren = 0; s.app_wdf_end = 1;
        s_addr = '{28'h100, 28'h108, 28'h110, 28'h100};
        s_data = '{128'hC0DE0000, 128'hC0DE0001, 128'hC0DE0002, 128'hC0DE0003};

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        check("rst_calib", m.init_calib_complete, 0);
        check("rst_rdy", m.app_rdy, 0);
        check("rst_wdf_rdy", m.app_wdf_rdy, 0);
        check("rst_rd_data", m.app_rd_data, 0);
        check("rst_valid", {m.app_rd_data_valid, m.app_rd_data_end}, 0);
        check("rst_error", m.error, 0);
        reset = 1'b0; cyc = 0;

        // Calibration edge
        repeat (15) tick();
        check("calib_early", m.init_calib_complete, 0);
        check("rdy_early", m.app_rdy, 0);
        tick();
        check("calib_16", m.init_calib_complete, 1);
        check("rdy_16", m.app_rdy, 1);
        check("wdf_rdy_16", m.app_wdf_rdy, 1);
        check("err_idle", m.error, 0);
        check("calib_16_s", s.init_calib_complete, 1);

        // Write then read with exact latency
        m.app_cmd = MIG_CMD_WRITE; m.app_addr = 28'h40; m.app_en = 1;
        m.app_wdf_data = D1; m.app_wdf_mask = 16'h0; m.app_wdf_end = 1; m.app_wdf_wren = 1;
        wait_m("wr1_accept");
        m.app_cmd = MIG_CMD_READ; m.app_addr = 28'h40; m.app_en = 1;
        step_m();
        check("rd1_accept", m.app_en, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rd1_lat_early", m.app_rd_data_valid, 0);
        end
        tick();
        check("rd1_valid", m.app_rd_data_valid, 1);
        check("rd1_end", m.app_rd_data_end, 1);
        check("rd1_data", m.app_rd_data, D1);
        tick();
        check("rd1_pulse", {m.app_rd_data_valid, m.app_rd_data_end}, 0);
        check("rd1_hold", m.app_rd_data, D1);

        // Data ahead of command, partial byte mask
        m.app_cmd = MIG_CMD_WRITE; m.app_addr = 28'h80; m.app_en = 1;
        m.app_wdf_data = F11; m.app_wdf_mask = 16'h0; m.app_wdf_wren = 1;
        wait_m("wr11_accept");
        send_data_m(D2, 16'hFFF0);
        tick();
        tick();
        check("early_data_wdf_rdy", m.app_wdf_rdy, 1);
        send_cmd_m(MIG_CMD_WRITE, 28'h80);
        read_check_m(28'h80, DM, "masked_rd");

        // Command FIFO fills behind a data-starved write
        for (int i = 0; i < 4; i++) send_cmd_m(MIG_CMD_WRITE, 28'h200 + 28'(8*i));
        check("full_rdy", m.app_rdy, 0);
        check("full_wdf_rdy", m.app_wdf_rdy, 1);
        m.app_cmd = MIG_CMD_WRITE; m.app_addr = 28'h220; m.app_en = 1;
        step_m();
        check("fifth_blocked", {m.app_en, m.app_rdy}, 2'b10);
        for (int i = 0; i < 5; i++) send_data_m(128'(i + 1), 16'h0);
        repeat (6) step_m();
        check("fifth_accepted", m.app_en, 0);
        check("rdy_back", m.app_rdy, 1);
        read_check_m(28'h220, 128'd5, "fifo_rd5");
        read_check_m(28'h200, 128'd1, "fifo_rd1");
        check("err_clean", m.error, 0);

        // Beat without end flag
        m.app_wdf_data = 128'hBAD; m.app_wdf_end = 0; m.app_wdf_wren = 1;
        step_m();
        m.app_wdf_end = 1;
        check("err_no_end", m.error, 4'b0010);

        // Reset with two reads in flight
        send_cmd_m(MIG_CMD_READ, 28'h40);
        send_cmd_m(MIG_CMD_READ, 28'h80);
        cnt0 = m_vld_cnt;
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_calib", m.init_calib_complete, 0);
        check("mid_rst_rdy", {m.app_rdy, m.app_wdf_rdy}, 0);
        check("mid_rst_valid", m.app_rd_data_valid, 0);
        check("mid_rst_data", m.app_rd_data, 0);
        check("mid_rst_error", m.error, 0);
        reset = 1'b0; cyc = 0;
        m.app_cmd = MIG_CMD_READ; m.app_addr = 28'h0; m.app_en = 1;
        tick();
        m.app_en = 0;
        check("err_precal", m.error, 4'b0100);
        repeat (14) tick();
        check("recal_early", m.init_calib_complete, 0);
        tick();
        check("recal_16", m.init_calib_complete, 1);
        check("no_stale_valid", m_vld_cnt, cnt0);
        read_check_m(28'h40, D1, "post_rst_rd");
        read_check_m(28'h220, 128'd5, "post_rst_rd5");

        // Stalled responder: interleaved writes and reads
        for (int i = 0; i < 8; i++) begin
            s.app_cmd = (i % 2 == 0) ? MIG_CMD_WRITE : MIG_CMD_READ;
            s.app_addr = s_addr[i/2];
            s.app_en = 1;
            if (i % 2 == 0) begin
                s.app_wdf_data = s_data[i/2]; s.app_wdf_mask = 16'h0;
                s.app_wdf_end = 1; s.app_wdf_wren = 1;
            end
            wait_s("s_accept");
        end
        repeat (8) step_s();
        check("s_rd_count", q_s.size(), 4);
        for (int i = 0; i < 4; i++) check("s_rd_data", q_s[i], s_data[i]);

        // Unknown opcode is flagged and never executed
        s.app_cmd = 3'b111; s.app_addr = 28'h108; s.app_en = 1;
        wait_s("s_bad_accept");
        repeat (8) step_s();
        check("s_err_bad_cmd", s.error, 4'b0001);
        check("s_bad_no_read", q_s.size(), 4);
        s.app_cmd = MIG_CMD_READ; s.app_addr = 28'h108; s.app_en = 1;
        wait_s("s_rd_after_bad");
        repeat (8) step_s();
        check("s_rd_after_bad_cnt", q_s.size(), 5);
        check("s_rd_after_bad_data", q_s[4], s_data[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mig_app_responder.md
MIG_APP_RESPONDER -- requirements
Module: mig_app_responder

Interface
REQ-001 Parameter CHUNK_PART, 128, data beat width in bits.
REQ-002 Parameter ADDRESS_SIZE, 28, app address width.
REQ-003 Parameter DEPTH_LOG2, 10, log2 of backing-store beats.
REQ-004 Parameter READ_LATENCY, 4, cycles from read execution to rd_data_valid (min 1).
REQ-005 Parameter CALIB_CYCLES, 16, cycles after reset before calibration completes.
REQ-006 Parameter STALL_PERIOD, 0, forced app_rdy low one cycle every STALL_PERIOD cycles; 0 disables.
REQ-007 clk  in  1  single clock, equivalent of ui_clk; one clock, all logic on posedge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 app_addr  in  ADDRESS_SIZE  command address.
REQ-010 app_cmd  in  3  000 write, 001 read.
REQ-011 app_en  in  1  command valid.
REQ-012 app_rdy  out  1  command accept.
REQ-013 app_wdf_data  in  CHUNK_PART  write data.
REQ-014 app_wdf_mask  in  CHUNK_PART/8  byte mask, 1 = byte not written.
REQ-015 app_wdf_wren / app_wdf_end  in  1 each  write data valid / last beat.
REQ-016 app_wdf_rdy  out  1  write data accept.
REQ-017 app_rd_data  out  CHUNK_PART  read data.
REQ-018 app_rd_data_valid / app_rd_data_end  out  1 each  read beat valid / last beat.
REQ-019 init_calib_complete  out  1  calibration done.
REQ-020 error  out  4  sticky protocol error flags.

Function
REQ-021 Calibration: counter runs from reset; init_calib_complete rises exactly CALIB_CYCLES cycles after reset deasserts, then stays high.
REQ-022 app_rdy = calib done AND cmd FIFO not full AND not stall cycle; app_wdf_rdy = calib done AND data FIFO not full.
REQ-023 Command accepted when app_en && app_rdy; {cmd, addr} pushed to 4-entry command FIFO same cycle.
REQ-024 Write beat accepted when app_wdf_wren && app_wdf_rdy; {data, mask} pushed to 4-entry data FIFO; data may precede its command.
REQ-025 Beat index = app_addr[3 +: DEPTH_LOG2] (8 columns per 128-bit beat); higher bits ignored, aliasing permitted.
REQ-026 Execution strictly in acceptance order, at most one command per cycle, from cmd FIFO head.
REQ-027 Head write executes only when data FIFO non-empty: pops both, writes unmasked bytes; masked bytes keep old contents.
REQ-028 Head write with empty data FIFO blocks the head (later reads included), guaranteeing read-after-write coherence.
REQ-029 Head read executes immediately: store read, result enters a READ_LATENCY-deep pipeline; app_rd_data_valid and app_rd_data_end pulse together for 1 cycle per read, in order.
REQ-030 app_rd_data holds last returned value when valid low.
REQ-031 Simultaneous push and pop on either FIFO in same cycle is legal at any occupancy, including full.
REQ-032 error[0] sticky: accepted cmd other than 000/001 (command discarded, not executed).
REQ-033 error[1] sticky: app_wdf_wren without app_wdf_end (beat still accepted).
REQ-034 error[2] sticky: app_en or app_wdf_wren asserted before init_calib_complete.
REQ-035 error[3] reserved, always 0.

Reset
REQ-036 Reset values: app_rdy 0, app_wdf_rdy 0, app_rd_data 0, app_rd_data_valid 0, app_rd_data_end 0, init_calib_complete 0, error 0.
REQ-037 Reset mid-operation flushes both FIFOs and read pipeline (in-flight reads never return), restarts calibration counter.
REQ-038 Backing store contents are not cleared by reset.

Structure
REQ-039 Shared package mig_app_pkg holds MIG_CMD_WRITE=3'b000, MIG_CMD_READ=3'b001 and the command-entry typedef {cmd, addr}.
REQ-040 Sub-module SYNC_FIFO (parameterised width/depth, sync active-high reset, full/empty) instantiated for command and data FIFOs.
REQ-041 Backing store is an inferred single-port RAM of 2**DEPTH_LOG2 x CHUNK_PART.

Verification
REQ-042 Reset, idle -> init_calib_complete rises at cycle 16, app_rdy/app_wdf_rdy high cycle 16, error 0.
REQ-043 Write addr 0x40 data 0x...DEADBEEF mask 0, then read 0x40 -> valid+end 4 cycles after read executes, data 0x...DEADBEEF.
REQ-044 Write data 2 cycles before write cmd to 0x80, mask 16'hFFF0 over prior 0x11..11 -> read returns low 4 bytes new, upper 12 bytes 0x11.
REQ-045 Five back-to-back write cmds with no data -> app_rdy low after 4th; supply data -> all execute, app_rdy returns high.
REQ-046 STALL_PERIOD=3, 8 interleaved reads/writes -> app_rdy low every 3rd cycle, read data matches order; app_cmd=3'b111 -> error[0]=1, no execution.
REQ-047 Reset asserted with 2 reads in pipeline -> no rd_data_valid afterward, prior written data still readable after recalibration.
